// File: rtl/boa_stall_ctrl.sv
// boa_stall_ctrl: central hazard/stall scheduler for the Boa32 pipeline.
// It resolves, in priority order:
//   1. data-bus wait states (mem_busy)
//   2. fixed-latency multi-cycle EX ops
//   3. branch-mispredict flushes
//   4. load-use hazards
// It drives the stall, flush and bubble controls for IF/ID/EX/MEM.
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   id_*                   ID-stage operand usage and register indices
//   ex_*                   EX-stage load info, multi-cycle start, mispredict
//   mem_busy               data-bus wait state in MEM
//   fw_stall_{if,id,ex,mem} stage hold controls
//   fw_flush_id            invalidate IF/ID
//   fw_bubble_{ex,mem}     insert an invalid entry into ID/EX or EX/MEM
//   fw_mc_last             multi-cycle result valid in EX this cycle
//   perf_stall_cnt         stall-cycle counter
//
// Compile-time option:
//   BOA_STALL_PERF_EN  builds the stall-cycle counter; otherwise
//                      perf_stall_cnt is tied to zero.
//
// All outputs are combinational from state and inputs, and are forced
// low while rst is asserted.
module boa_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mc_start,
  input  logic        ex_mispredict,
  input  logic        mem_busy,
  output logic        fw_stall_if,
  output logic        fw_stall_id,
  output logic        fw_stall_ex,
  output logic        fw_stall_mem,
  output logic        fw_flush_id,
  output logic        fw_bubble_ex,
  output logic        fw_bubble_mem,
  output logic        fw_mc_last,
  output logic [31:0] perf_stall_cnt
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERF_W = 32;

  typedef enum logic {ST_RUN = 1'b0, ST_MC = 1'b1} state_e;

  state_e           st, st_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             flush_pend, flush_pend_d;

  logic stall_if_r, stall_id_r, stall_ex_r, stall_mem_r;
  logic flush_id_r, bubble_ex_r, bubble_mem_r, mc_last_r;
  logic load_use;

  // Load-use hazard; x0 never produces a dependency.
  assign load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= ST_RUN;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      st         <= st_d;
      cnt        <= cnt_d;
      flush_pend <= flush_pend_d;
    end
  end

  // Prioritised next-state and raw control decode.
  always_comb begin
    st_d         = st;
    cnt_d        = cnt;
    flush_pend_d = flush_pend;
    stall_if_r   = 1'b0;
    stall_id_r   = 1'b0;
    stall_ex_r   = 1'b0;
    stall_mem_r  = 1'b0;
    flush_id_r   = 1'b0;
    bubble_ex_r  = 1'b0;
    bubble_mem_r = 1'b0;
    mc_last_r    = 1'b0;

    if (mem_busy) begin
      stall_if_r  = 1'b1;
      stall_id_r  = 1'b1;
      stall_ex_r  = 1'b1;
      stall_mem_r = 1'b1;
      // Remember a mispredict seen while frozen; it is ignored during MC.
      if (st == ST_RUN && ex_mispredict) flush_pend_d = 1'b1;
      // The multi-cycle unit keeps counting under a bus wait.
      if (st == ST_MC && cnt != '0) cnt_d = cnt - CNT_W'(1);
    end else if (st == ST_MC) begin
      if (cnt != '0) begin
        stall_if_r   = 1'b1;
        stall_id_r   = 1'b1;
        stall_ex_r   = 1'b1;
        bubble_mem_r = 1'b1;
        cnt_d        = cnt - CNT_W'(1);
      end else begin
        mc_last_r = 1'b1;
        st_d      = ST_RUN;
      end
    end else if (ex_mc_start) begin
      stall_if_r   = 1'b1;
      stall_id_r   = 1'b1;
      stall_ex_r   = 1'b1;
      bubble_mem_r = 1'b1;
      cnt_d        = CNT_W'(DIV_CYCLES - 1);
      st_d         = ST_MC;
    end else if (ex_mispredict || flush_pend) begin
      // No stall: IF fetches the redirect target; the ID instruction is dropped.
      flush_id_r   = 1'b1;
      bubble_ex_r  = 1'b1;
      flush_pend_d = 1'b0;
    end else if (load_use) begin
      stall_if_r  = 1'b1;
      stall_id_r  = 1'b1;
      bubble_ex_r = 1'b1;
    end
  end

  // Outputs held low while reset is asserted.
  assign fw_stall_if   = rst & stall_if_r;
  assign fw_stall_id   = rst & stall_id_r;
  assign fw_stall_ex   = rst & stall_ex_r;
  assign fw_stall_mem  = rst & stall_mem_r;
  assign fw_flush_id   = rst & flush_id_r;
  assign fw_bubble_ex  = rst & bubble_ex_r;
  assign fw_bubble_mem = rst & bubble_mem_r;
  assign fw_mc_last    = rst & mc_last_r;

`ifdef BOA_STALL_PERF_EN
  logic [PERF_W-1:0] perf_q;

  // Stall-cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (fw_stall_if) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = PERF_W'(0);
`endif

endmodule

// File: tb/tb_boa_stall_ctrl.sv
// Directed bench for boa_stall_ctrl with DIV_CYCLES=4.
module tb_boa_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rs1, id_rs2;
  logic        ex_valid, ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_mc_start, ex_mispredict, mem_busy;
  logic        fw_stall_if, fw_stall_id, fw_stall_ex, fw_stall_mem;
  logic        fw_flush_id, fw_bubble_ex, fw_bubble_mem, fw_mc_last;
  logic [31:0] perf_stall_cnt;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] exp_perf;

  // Expected output codes: {stall_if,id,ex,mem, flush_id, bubble_ex, bubble_mem, mc_last}
  localparam logic [7:0] IDLE  = 8'b0000_0000;
  localparam logic [7:0] LDUSE = 8'b1100_0100;
  localparam logic [7:0] MCST  = 8'b1110_0010;
  localparam logic [7:0] FULL  = 8'b1111_0000;
  localparam logic [7:0] FLUSH = 8'b0000_1100;
  localparam logic [7:0] LAST  = 8'b0000_0001;

  boa_stall_ctrl #(.DIV_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_mc_start    (ex_mc_start),
    .ex_mispredict  (ex_mispredict),
    .mem_busy       (mem_busy),
    .fw_stall_if    (fw_stall_if),
    .fw_stall_id    (fw_stall_id),
    .fw_stall_ex    (fw_stall_ex),
    .fw_stall_mem   (fw_stall_mem),
    .fw_flush_id    (fw_flush_id),
    .fw_bubble_ex   (fw_bubble_ex),
    .fw_bubble_mem  (fw_bubble_mem),
    .fw_mc_last     (fw_mc_last),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check one cycle's outputs mid-cycle, then advance to the next negedge.
  task automatic step(input string tag, input logic [7:0] exp);
    logic [7:0]  obs;
    logic [31:0] exp_p;
    #1;
    obs = {fw_stall_if, fw_stall_id, fw_stall_ex, fw_stall_mem,
           fw_flush_id, fw_bubble_ex, fw_bubble_mem, fw_mc_last};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
`ifdef BOA_STALL_PERF_EN
    exp_p = exp_perf;
`else
    exp_p = 32'd0;
`endif
    vectors++;
    assert (perf_stall_cnt === exp_p) else begin
      miscompares++;
      $error("FAIL %s_perf: perf_stall_cnt observed %0d expected %0d", tag, perf_stall_cnt, exp_p);
    end
    if (exp[7]) exp_perf = exp_perf + 32'd1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    ex_mc_start = 1'b0; ex_mispredict = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_perf = 32'd0;
    clear_inputs();
    rst = 1'b0;

    // Reset: outputs forced low even with active hazard inputs.
    @(negedge clk);
    mem_busy = 1'b1; ex_mc_start = 1'b1;
    step("reset_busy", IDLE);
    step("reset_hold", IDLE);
    clear_inputs();
    rst = 1'b1;
    step("idle", IDLE);

    // Load-use on rs2, then load moves to MEM.
    set_load(5'd5); id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    step("lduse_rs2", LDUSE);
    clear_inputs(); id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd5;
    step("lduse_clear", IDLE);

    // Load-use on rs1; rs1 match without use flag; non-load; x0.
    clear_inputs(); set_load(5'd7); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd7;
    step("lduse_rs1", LDUSE);
    id_use_rs1 = 1'b0;
    step("no_use_flag", IDLE);
    id_use_rs1 = 1'b1; ex_is_load = 1'b0;
    step("not_load", IDLE);
    clear_inputs(); set_load(5'd0); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd0;
    step("x0_no_hazard", IDLE);
    id_valid = 1'b0; id_rs1 = 5'd0; set_load(5'd9); id_use_rs1 = 1'b1; id_rs1 = 5'd9;
    step("id_invalid", IDLE);

    // Multi-cycle op, DIV_CYCLES=4; mispredict in MC is ignored.
    clear_inputs(); ex_mc_start = 1'b1;
    step("mc_t0", MCST);
    ex_mc_start = 1'b0;
    step("mc_t1", MCST);
    ex_mispredict = 1'b1; ex_mc_start = 1'b1;
    step("mc_t2_ign", MCST);
    ex_mispredict = 1'b0; ex_mc_start = 1'b0;
    step("mc_t3", MCST);
    step("mc_t4_last", LAST);
    step("mc_t5_idle", IDLE);

    // Multi-cycle op with bus wait on T3..T5.
    ex_mc_start = 1'b1;
    step("mcb_t0", MCST);
    ex_mc_start = 1'b0;
    step("mcb_t1", MCST);
    step("mcb_t2", MCST);
    mem_busy = 1'b1;
    step("mcb_t3", FULL);
    step("mcb_t4", FULL);
    step("mcb_t5", FULL);
    mem_busy = 1'b0;
    step("mcb_t6_last", LAST);
    step("mcb_t7_idle", IDLE);

    // Mispredict held under bus wait, then a single flush.
    ex_mispredict = 1'b1; mem_busy = 1'b1;
    step("mp_busy0", FULL);
    step("mp_busy1", FULL);
    mem_busy = 1'b0;
    step("mp_flush", FLUSH);
    ex_mispredict = 1'b0;
    step("mp_done", IDLE);

    // Pending flush replays after the mispredict input drops.
    ex_mispredict = 1'b1; mem_busy = 1'b1;
    step("pend_busy", FULL);
    ex_mispredict = 1'b0; mem_busy = 1'b0;
    step("pend_flush", FLUSH);
    step("pend_done", IDLE);

    // Flush suppresses load-use; bus wait suppresses the bubble.
    set_load(5'd3); id_valid = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
    ex_mispredict = 1'b1;
    step("flush_over_lduse", FLUSH);
    ex_mispredict = 1'b0; mem_busy = 1'b1;
    step("busy_over_lduse", FULL);
    clear_inputs();
    step("idle2", IDLE);

    // Reset mid-MC with cnt=2: no mc_last after release.
    ex_mc_start = 1'b1;
    step("mcr_t0", MCST);
    ex_mc_start = 1'b0;
    step("mcr_t1", MCST);
    rst = 1'b0;
    exp_perf = 32'd0;
    step("mcr_rst0", IDLE);
    step("mcr_rst1", IDLE);
    rst = 1'b1;
    step("mcr_post0", IDLE);
    step("mcr_post1", IDLE);
    step("mcr_post2", IDLE);
    step("mcr_post3", IDLE);

    // Counter resumes counting after reset.
    set_load(5'd12); id_valid = 1'b1; id_use_rs2 = 1'b1; id_rs2 = 5'd12;
    step("post_lduse", LDUSE);
    clear_inputs();
    step("post_idle", IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boa_stall_ctrl.md
Name: boa_stall_ctrl

Overview:
Central hazard and stall scheduler for the Boa³² pipeline. It generates the fw_stall_* and flush/bubble controls consumed by the IF, ID, EX and MEM stages. It resolves four hazard sources:
- data-bus wait states
- fixed-latency multi-cycle EX operations (divider)
- branch mispredict flushes
- load-use hazards

It replaces ad-hoc stall wiring between stages with one prioritised, stateful controller.

Parameters:
DIV_CYCLES, 16, latency of a multi-cycle EX op in cycles; legal range 1..255.

Ports:
clk  in  1  CPU clock.
rst  in  1  asynchronous active-low reset.
id_valid  in  1  ID holds a valid instruction.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
id_rs1  in  5  ID rs1 index.
id_rs2  in  5  ID rs2 index.
ex_valid  in  1  EX holds a valid instruction.
ex_is_load  in  1  EX instruction is a load.
ex_rd  in  5  EX destination register.
ex_mc_start  in  1  EX is beginning a multi-cycle op; held while EX is stalled.
ex_mispredict  in  1  EX resolved a mispredicted branch; held while EX is stalled.
mem_busy  in  1  data bus wait state in MEM.
fw_stall_if  out  1  hold IF.
fw_stall_id  out  1  hold ID.
fw_stall_ex  out  1  hold EX.
fw_stall_mem  out  1  hold MEM.
fw_flush_id  out  1  invalidate the IF/ID register.
fw_bubble_ex  out  1  load an invalid entry into ID/EX.
fw_bubble_mem  out  1  load an invalid entry into EX/MEM.
fw_mc_last  out  1  multi-cycle result valid in EX this cycle.
perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- State: st ∈ {RUN, MC}, cnt[7:0], flush_pend.
  - Reset values: RUN, 0, 0.
  - While rst=0 all outputs are forced to 0.
- All outputs are combinational from state and inputs. State updates on rising clk.

Priority order (highest first):
- P1 mem_busy=1:
  - fw_stall_if/id/ex/mem=1.
  - No flush or bubble outputs.
  - ex_mispredict=1 sets flush_pend.
  - ex_mc_start is ignored; EX re-presents it.
- P2 MC multi-cycle handling:
  - Start: st=RUN, ex_mc_start=1, mem_busy=0. Set cnt←DIV_CYCLES−1, st←MC. Assert fw_stall_if/id/ex=1 and fw_bubble_mem=1 this cycle.
  - In st=MC, cnt≠0: stall IF/ID/EX, fw_bubble_mem=1, cnt decrements. The decrement also happens when mem_busy=1.
  - In st=MC, cnt=0, mem_busy=0: fw_mc_last=1, no stall, st←RUN.
  - In st=MC, cnt=0, mem_busy=1: hold in MC with cnt=0; P1 outputs apply.
  - Total stall is DIV_CYCLES cycles; fw_mc_last is asserted DIV_CYCLES cycles after the start cycle.
  - DIV_CYCLES=1: stall only in the start cycle; fw_mc_last is asserted the next cycle.
  - ex_mispredict or ex_mc_start asserted in MC: ignored.
- P3 flush, triggered by (ex_mispredict | flush_pend) with mem_busy=0 in RUN:
  - fw_flush_id=1, fw_bubble_ex=1.
  - No stall, so IF loads the redirect target.
  - flush_pend←0.
  - Load-use is suppressed this cycle because the ID instruction is discarded.
- P4 load-use hazard:
  - Condition: ex_valid & ex_is_load & ex_rd≠0 & id_valid & ((id_use_rs1 & id_rs1=ex_rd) | (id_use_rs2 & id_rs2=ex_rd)).
  - Response: fw_stall_if/id=1, fw_bubble_ex=1.
  - Single cycle; it clears once the load advances to MEM.
- Register x0 never causes a hazard.
- fw_stall_mem is asserted only under P1.
- An outer stage never runs while an inner stage stalls: stall_if ≥ stall_id ≥ stall_ex ≥ stall_mem.
- Reset asserted mid-MC: state returns to RUN immediately (asynchronously) and cnt clears. No fw_mc_last is produced for the aborted op.

Optional Feature:
Macro BOA_STALL_PERF_EN.
- Defined:
  - perf_stall_cnt increments by 1 every cycle fw_stall_if=1.
  - It wraps 0xFFFFFFFF→0 and resets to 0.
- Undefined:
  - perf_stall_cnt is tied to 0 and no counter register is built.
  - The port remains present.

Test Plan:
- Load-use: EX load ex_rd=5, ID id_rs2=5, id_use_rs2=1 → one cycle of stall_if/id=1, bubble_ex=1; the next cycle (load in MEM) has all outputs 0.
- ex_rd=0 with id_rs1=0 and id_use_rs1=1, EX a load → no stall.
- DIV_CYCLES=4: ex_mc_start pulse at T0 → stall_if/id/ex=1 and bubble_mem=1 for T0..T3; fw_mc_last=1 at T4; all outputs idle at T5.
- DIV_CYCLES=4 with mem_busy=1 on T3..T5 after a start at T0 → stall_mem=1 for T3..T5; fw_mc_last=1 at T6 only.
- ex_mispredict=1 with mem_busy=1 for 2 cycles, then mem_busy=0 → full stall for 2 cycles, then exactly one cycle of flush_id=1 and bubble_ex=1.
- Reset asserted in MC with cnt=2 → all outputs 0 during reset; after release no fw_mc_last. With BOA_STALL_PERF_EN defined, perf_stall_cnt=0 after reset and increases by exactly the number of stall_if cycles in the preceding scenarios.
